// File: rtl/mp3_tx.sv
// Serial byte transmitter for an MP3 decoder data port (clk/sync/data/req).
// One-byte holding register in front of an MSB-first shifter driving a gated serial clock.
module mp3_tx #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       mp3_clk,
  output logic       mp3_sync,
  output logic       mp3_dat,
  input  logic       mp3_req,
  output logic       busy,
  output logic       byte_done
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t     state_q;
  logic [7:0] divcnt_q;
  logic [2:0] bitcnt_q;
  logic [7:0] hold_q;
  logic [7:0] shift_q;
  logic       hold_full_q;
  logic       hold_full_d;
  logic       req_meta_q;
  logic       req_s_q;
  logic       clk_q;
  logic       sync_q;
  logic       dat_q;
  logic       done_q;

  logic accept;
  logic phase_end;
  logic mid_fall;
  logic last_fall;
  logic start;

  assign accept    = din_vld & ~hold_full_q;
  assign phase_end = (divcnt_q == 8'd0);
  assign mid_fall  = (state_q == HI) && phase_end && (bitcnt_q != 3'd0);
  assign last_fall = (state_q == HI) && phase_end && (bitcnt_q == 3'd0);
  // req_s only matters at byte boundaries, so a mid-byte drop never truncates a byte
  assign start     = hold_full_q && req_s_q && ((state_q == IDLE) || last_fall);

  assign hold_full_d = accept ? 1'b1 : (start ? 1'b0 : hold_full_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      divcnt_q    <= 8'd0;
      bitcnt_q    <= 3'd0;
      hold_full_q <= 1'b0;
      req_meta_q  <= 1'b0;
      req_s_q     <= 1'b0;
      clk_q       <= 1'b0;
      sync_q      <= 1'b0;
      dat_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      req_meta_q  <= mp3_req;
      req_s_q     <= req_meta_q;
      hold_full_q <= hold_full_d;
      done_q      <= last_fall;
      if (start) begin
        state_q  <= LO;
        divcnt_q <= DIV_M1;
        bitcnt_q <= 3'd7;
        clk_q    <= 1'b0;
        sync_q   <= 1'b1;
        dat_q    <= hold_q[7];
      end else begin
        case (state_q)
          IDLE: begin
            clk_q  <= 1'b0;
            sync_q <= 1'b0;
          end
          LO: begin
            if (phase_end) begin
              clk_q    <= 1'b1;
              divcnt_q <= DIV_M1;
              state_q  <= HI;
            end else begin
              divcnt_q <= divcnt_q - 8'd1;
            end
          end
          HI: begin
            if (phase_end) begin
              // data only moves on the falling edge so the decoder's rising-edge sample is clean
              clk_q    <= 1'b0;
              divcnt_q <= DIV_M1;
              sync_q   <= 1'b0;
              if (bitcnt_q != 3'd0) begin
                dat_q    <= shift_q[6];
                bitcnt_q <= bitcnt_q - 3'd1;
                state_q  <= LO;
              end else begin
                state_q  <= IDLE;
              end
            end else begin
              divcnt_q <= divcnt_q - 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) hold_q <= din;
    if (start) begin
      shift_q <= hold_q;
    end else if (mid_fall) begin
      shift_q <= {shift_q[6:0], 1'b0};
    end
  end

  assign din_rdy   = ~hold_full_q;
  assign busy      = (state_q != IDLE) | hold_full_q;
  assign mp3_clk   = clk_q;
  assign mp3_sync  = sync_q;
  assign mp3_dat   = dat_q;
  assign byte_done = done_q;

endmodule

// File: tb/tb_mp3_tx.sv
// Bench for mp3_tx: three instances (DIV=2, DIV=1, DIV=5) with a shared serial receiver monitor.
module tb_mp3_tx;
  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v  [3];
  logic [7:0] din_v  [3];
  logic       vld_v  [3];
  logic       req_v  [3];
  logic       rdy_o  [3];
  logic       mclk_o [3];
  logic       sync_o [3];
  logic       dat_o  [3];
  logic       busy_o [3];
  logic       bd_o   [3];

  mp3_tx #(.DIV(2)) u_a (.clk(clk), .rst(rst_v[0]), .din(din_v[0]), .din_vld(vld_v[0]),
    .din_rdy(rdy_o[0]), .mp3_clk(mclk_o[0]), .mp3_sync(sync_o[0]), .mp3_dat(dat_o[0]),
    .mp3_req(req_v[0]), .busy(busy_o[0]), .byte_done(bd_o[0]));
  mp3_tx #(.DIV(1)) u_b (.clk(clk), .rst(rst_v[1]), .din(din_v[1]), .din_vld(vld_v[1]),
    .din_rdy(rdy_o[1]), .mp3_clk(mclk_o[1]), .mp3_sync(sync_o[1]), .mp3_dat(dat_o[1]),
    .mp3_req(req_v[1]), .busy(busy_o[1]), .byte_done(bd_o[1]));
  mp3_tx #(.DIV(5)) u_c (.clk(clk), .rst(rst_v[2]), .din(din_v[2]), .din_vld(vld_v[2]),
    .din_rdy(rdy_o[2]), .mp3_clk(mclk_o[2]), .mp3_sync(sync_o[2]), .mp3_dat(dat_o[2]),
    .mp3_req(req_v[2]), .busy(busy_o[2]), .byte_done(bd_o[2]));

  // Receiver model: samples data/sync on each serial rising edge
  int   cyc;
  int   rx_n    [3];
  logic rx_bit  [3][512];
  logic rx_syn  [3][512];
  int   rx_t    [3][512];
  int   viol    [3];
  int   bd_n    [3];
  int   low_run [3];
  int   low_max [3];
  logic pclk    [3];
  logic pdat    [3];

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (mclk_o[g] === 1'b1 && pclk[g] === 1'b0) begin
        if (rx_n[g] < 512) begin
          rx_bit[g][rx_n[g]] = dat_o[g];
          rx_syn[g][rx_n[g]] = sync_o[g];
          rx_t[g][rx_n[g]]   = cyc;
        end
        rx_n[g]++;
      end
      if (rst_v[g] === 1'b0 && mclk_o[g] === 1'b1 && dat_o[g] !== pdat[g]) viol[g]++;
      if (bd_o[g] === 1'b1) bd_n[g]++;
      if (rdy_o[g] === 1'b0) begin
        low_run[g]++;
        if (low_run[g] > low_max[g]) low_max[g] = low_run[g];
      end else begin
        low_run[g] = 0;
      end
      pclk[g] = mclk_o[g];
      pdat[g] = dat_o[g];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    int w;
    w = 0;
    while (rdy_o[g] !== 1'b1 && w < 3000) begin
      tick(1);
      w++;
    end
    if (w >= 3000) chk("push_rdy_timeout", w, 0);
    din_v[g] = b;
    vld_v[g] = 1'b1;
    tick(1);
    vld_v[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int lim);
    int w;
    w = 0;
    while (busy_o[g] !== 1'b0 && w < lim) begin
      tick(1);
      w++;
    end
    chk("wait_idle", int'(busy_o[g]), 0);
  endtask

  task automatic wait_edges(input int g, input int base, input int n, input int lim);
    int w;
    w = 0;
    while ((rx_n[g] - base) < n && w < lim) begin
      tick(1);
      w++;
    end
    chk("wait_edges", rx_n[g] - base, n);
  endtask

  function automatic logic [7:0] rx_byte(input int g, input int idx);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = rx_bit[g][idx+i];
    return r;
  endfunction

  function automatic logic [7:0] rx_sbyte(input int g, input int idx);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = rx_syn[g][idx+i];
    return r;
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [7:0] bits;
    logic [7:0] syncs;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int base;
    int bd0;
    int e;
    int bad;
    logic [31:0] sv;

    tbl[0] = '{din: 8'hA5, bits: 8'b1010_0101, syncs: 8'b1000_0000};
    tbl[1] = '{din: 8'h00, bits: 8'b0000_0000, syncs: 8'b1000_0000};
    tbl[2] = '{din: 8'hFF, bits: 8'b1111_1111, syncs: 8'b1000_0000};
    tbl[3] = '{din: 8'h3C, bits: 8'b0011_1100, syncs: 8'b1000_0000};
    tbl[4] = '{din: 8'h81, bits: 8'b1000_0001, syncs: 8'b1000_0000};
    tbl[5] = '{din: 8'h6B, bits: 8'b0110_1011, syncs: 8'b1000_0000};

    for (int g = 0; g < 3; g++) begin
      rst_v[g] = 1'b1;
      din_v[g] = 8'h00;
      vld_v[g] = 1'b0;
      req_v[g] = 1'b0;
    end
    tick(2);
    chk("rst_rdy", int'(rdy_o[A]), 1);
    chk("rst_mclk", int'(mclk_o[A]), 0);
    chk("rst_sync", int'(sync_o[A]), 0);
    chk("rst_dat", int'(dat_o[A]), 0);
    chk("rst_busy", int'(busy_o[A]), 0);
    chk("rst_done", int'(bd_o[A]), 0);
    for (int g = 0; g < 3; g++) begin
      rst_v[g] = 1'b0;
      req_v[g] = 1'b1;
    end
    tick(4);

    // Cycle-exact latency of one byte, DIV=2
    base = rx_n[A];
    bd0  = bd_n[A];
    push(A, 8'hA5);
    chk("lat_busy_held", int'(busy_o[A]), 1);
    chk("lat_rdy_held", int'(rdy_o[A]), 0);
    tick(1);
    chk("lat_sync_start", int'(sync_o[A]), 1);
    chk("lat_rdy_free", int'(rdy_o[A]), 1);
    chk("lat_dat_msb", int'(dat_o[A]), 1);
    tick(1);
    chk("lat_clk_lo", int'(mclk_o[A]), 0);
    tick(1);
    chk("lat_clk_rise", int'(mclk_o[A]), 1);
    tick(29);
    chk("lat_done_early", int'(bd_o[A]), 0);
    tick(1);
    chk("lat_done", int'(bd_o[A]), 1);
    chk("lat_clk_end", int'(mclk_o[A]), 0);
    tick(1);
    chk("lat_done_pulse", int'(bd_o[A]), 0);
    chk("lat_busy_end", int'(busy_o[A]), 0);
    chk("lat_edges", rx_n[A] - base, 8);
    chk("lat_bits", int'(rx_byte(A, base)), 8'hA5);
    chk("lat_done_cnt", bd_n[A] - bd0, 1);

    // Table of single bytes, DIV=2
    for (int i = 0; i < 6; i++) begin
      base = rx_n[A];
      bd0  = bd_n[A];
      push(A, tbl[i].din);
      wait_idle(A, 300);
      tick(4);
      chk("tbl_edges", rx_n[A] - base, 8);
      chk("tbl_bits", int'(rx_byte(A, base)), int'(tbl[i].bits));
      chk("tbl_sync", int'(rx_sbyte(A, base)), int'(tbl[i].syncs));
      chk("tbl_done_cnt", bd_n[A] - bd0, 1);
      chk("tbl_clk_idle", int'(mclk_o[A]), 0);
      chk("tbl_sync_idle", int'(sync_o[A]), 0);
      chk("tbl_rdy", int'(rdy_o[A]), 1);
    end

    // DIV=5, single byte 8'h01
    base = rx_n[C];
    push(C, 8'h01);
    tick(1);
    chk("d5_sync", int'(sync_o[C]), 1);
    tick(4);
    chk("d5_lo_end", int'(mclk_o[C]), 0);
    tick(1);
    chk("d5_rise", int'(mclk_o[C]), 1);
    tick(4);
    chk("d5_hi_end", int'(mclk_o[C]), 1);
    tick(1);
    chk("d5_fall", int'(mclk_o[C]), 0);
    chk("d5_sync_off", int'(sync_o[C]), 0);
    tick(69);
    chk("d5_done_early", int'(bd_o[C]), 0);
    tick(1);
    chk("d5_done", int'(bd_o[C]), 1);
    tick(1);
    chk("d5_busy_end", int'(busy_o[C]), 0);
    chk("d5_edges", rx_n[C] - base, 8);
    chk("d5_bits", int'(rx_byte(C, base)), 8'h01);
    chk("d5_sync_pat", int'(rx_sbyte(C, base)), 8'h80);

    // Streaming, DIV=1
    base = rx_n[B];
    push(B, 8'h00);
    push(B, 8'hFF);
    push(B, 8'h3C);
    push(B, 8'h81);
    wait_idle(B, 300);
    tick(3);
    chk("st_edges", rx_n[B] - base, 32);
    chk("st_b0", int'(rx_byte(B, base)), 8'h00);
    chk("st_b1", int'(rx_byte(B, base + 8)), 8'hFF);
    chk("st_b2", int'(rx_byte(B, base + 16)), 8'h3C);
    chk("st_b3", int'(rx_byte(B, base + 24)), 8'h81);
    for (int i = 0; i < 32; i++) sv[31-i] = rx_syn[B][base+i];
    chk("st_sync_pat", int'(sv), 32'h8080_8080);
    bad = 0;
    for (int i = 1; i < 32; i++) if (rx_t[B][base+i] - rx_t[B][base+i-1] != 2) bad++;
    chk("st_gaps", bad, 0);
    chk("st_rdy_low", int'(low_max[B] <= 16), 1);

    // req backpressure, DIV=2
    base = rx_n[A];
    bd0  = bd_n[A];
    push(A, 8'hC5);
    push(A, 8'h3A);
    wait_edges(A, base, 4, 200);
    req_v[A] = 1'b0;
    tick(40);
    chk("bp_edges_held", rx_n[A] - base, 8);
    chk("bp_b1", int'(rx_byte(A, base)), 8'hC5);
    chk("bp_done_cnt", bd_n[A] - bd0, 1);
    chk("bp_busy", int'(busy_o[A]), 1);
    chk("bp_clk", int'(mclk_o[A]), 0);
    req_v[A] = 1'b1;
    tick(1);
    chk("bp_sync_r1", int'(sync_o[A]), 0);
    tick(1);
    chk("bp_sync_r2", int'(sync_o[A]), 0);
    tick(1);
    chk("bp_sync_r3", int'(sync_o[A]), 1);
    wait_idle(A, 300);
    tick(2);
    chk("bp_edges", rx_n[A] - base, 16);
    chk("bp_b2", int'(rx_byte(A, base + 8)), 8'h3A);
    chk("bp_sync_pat", int'(rx_sbyte(A, base + 8)), 8'h80);

    // Holding register full while req=0
    req_v[A] = 1'b0;
    tick(4);
    base = rx_n[A];
    din_v[A] = 8'h11;
    vld_v[A] = 1'b1;
    tick(1);
    chk("hf_rdy1", int'(rdy_o[A]), 0);
    din_v[A] = 8'h22;
    tick(1);
    chk("hf_rdy2", int'(rdy_o[A]), 0);
    din_v[A] = 8'h33;
    tick(1);
    vld_v[A] = 1'b0;
    tick(20);
    chk("hf_no_edges", rx_n[A] - base, 0);
    chk("hf_busy", int'(busy_o[A]), 1);
    chk("hf_rdy3", int'(rdy_o[A]), 0);
    req_v[A] = 1'b1;
    push(A, 8'h22);
    push(A, 8'h33);
    wait_idle(A, 400);
    tick(2);
    chk("hf_edges", rx_n[A] - base, 24);
    chk("hf_b0", int'(rx_byte(A, base)), 8'h11);
    chk("hf_b1", int'(rx_byte(A, base + 8)), 8'h22);
    chk("hf_b2", int'(rx_byte(A, base + 16)), 8'h33);

    // Reset mid-byte during bit 3 of 8'h5A, with 8'hFF held
    base = rx_n[A];
    push(A, 8'h5A);
    push(A, 8'hFF);
    wait_edges(A, base, 5, 200);
    chk("rm_dat_before", int'(dat_o[A]), 1);
    rst_v[A] = 1'b1;
    #1;
    chk("rm_clk", int'(mclk_o[A]), 0);
    chk("rm_sync", int'(sync_o[A]), 0);
    chk("rm_dat", int'(dat_o[A]), 0);
    chk("rm_busy", int'(busy_o[A]), 0);
    chk("rm_done", int'(bd_o[A]), 0);
    chk("rm_rdy", int'(rdy_o[A]), 1);
    e = rx_n[A];
    tick(3);
    rst_v[A] = 1'b0;
    tick(10);
    chk("rm_no_edges", rx_n[A] - e, 0);
    chk("rm_idle", int'(busy_o[A]), 0);
    base = rx_n[A];
    push(A, 8'hC3);
    wait_idle(A, 300);
    tick(2);
    chk("rm_edges", rx_n[A] - base, 8);
    chk("rm_bits", int'(rx_byte(A, base)), 8'hC3);
    chk("rm_sync_pat", int'(rx_sbyte(A, base)), 8'h80);

    chk("dat_stable_a", viol[A], 0);
    chk("dat_stable_b", viol[B], 0);
    chk("dat_stable_c", viol[C], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
